// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 6-to-1 byte multiplexer: steps the select through a
// latched channel mask, waits a settle time, captures the byte and streams it out.
module mux_scan_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_CH  = 6,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   mux_sel,
  input  logic [DATA_W-1:0]  mux_in,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t              state, state_nxt;
  logic [NUM_CH-1:0]   mask_q, mask_nxt;
  logic [DWELL_W-1:0]  dwell_q, dwell_nxt;
  logic                cont_q, cont_nxt;
  logic [DWELL_W-1:0]  cnt, cnt_nxt;
  logic                stop_pending, stop_nxt;
  logic [SEL_W-1:0]    sel_nxt, ch_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                valid_nxt, done_nxt;

  logic [SEL_W-1:0]    low_in, low_q, hi_q;
  logic                has_hi;

  // Priority search: lowest set bit of the incoming / latched mask, and next set bit above mux_sel.
  always_comb begin
    low_in = '0;
    low_q  = '0;
    hi_q   = '0;
    has_hi = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i]) low_in = SEL_W'(i);
      if (mask_q[i])  low_q  = SEL_W'(i);
      if (mask_q[i] && (i > int'(mux_sel))) begin
        hi_q   = SEL_W'(i);
        has_hi = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_q;
    dwell_nxt = dwell_q;
    cont_nxt  = cont_q;
    cnt_nxt   = cnt;
    stop_nxt  = stop_pending;
    sel_nxt   = mux_sel;
    data_nxt  = out_data;
    ch_nxt    = out_ch;
    valid_nxt = out_valid;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start && (ch_mask != '0)) begin
          mask_nxt  = ch_mask;
          dwell_nxt = dwell;
          cont_nxt  = cont;
          sel_nxt   = low_in;
          cnt_nxt   = dwell;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (stop) stop_nxt = 1'b1;
        if (cnt != '0) begin
          cnt_nxt = cnt - DWELL_W'(1);
        end else begin
          data_nxt  = mux_in;
          ch_nxt    = mux_sel;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (stop) stop_nxt = 1'b1;
        if (out_ready) begin
          valid_nxt = 1'b0;
          if (!has_hi) done_nxt = 1'b1;
          if (stop_pending) begin
            state_nxt = IDLE;
          end else if (has_hi) begin
            sel_nxt   = hi_q;
            cnt_nxt   = dwell_q;
            state_nxt = SETTLE;
          end else if (cont_q) begin
            sel_nxt   = low_q;
            cnt_nxt   = dwell_q;
            state_nxt = SETTLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A pending stop only lives for the scan it was raised in.
    if (state_nxt == IDLE) stop_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mask_q       <= '0;
      dwell_q      <= '0;
      cont_q       <= 1'b0;
      cnt          <= '0;
      stop_pending <= 1'b0;
      mux_sel      <= '0;
      out_data     <= '0;
      out_ch       <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      mask_q       <= mask_nxt;
      dwell_q      <= dwell_nxt;
      cont_q       <= cont_nxt;
      cnt          <= cnt_nxt;
      stop_pending <= stop_nxt;
      mux_sel      <= sel_nxt;
      out_data     <= data_nxt;
      out_ch       <= ch_nxt;
      out_valid    <= valid_nxt;
      busy         <= (state_nxt != IDLE);
      frame_done   <= done_nxt;
    end
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly around the 6-to-1 byte multiplexer.
- Drives the multiplexer's 3-bit select upstream and captures the selected byte downstream.
- Steps through a programmable subset of the six sources, holding each select for a programmable settle time, then samples the byte.
- Presents each sample as a (channel, data) word on a valid/ready output stream, in single-frame or continuous mode.

Parameters:
- DATA_W, 8, width of the multiplexer data byte.
- NUM_CH, 6, number of selectable sources; channel indices 0..NUM_CH-1.
- SEL_W, 3, width of select and channel index.
- DWELL_W, 8, width of the settle-count input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan.
- stop  input  1  request to end scanning after the current channel.
- cont  input  1  1 = continuous frames, 0 = single frame; latched at start.
- ch_mask  input  NUM_CH  enabled channels, bit i = channel i; latched at start.
- dwell  input  DWELL_W  extra settle cycles before capture; latched at start.
- mux_sel  output  SEL_W  select driven to the multiplexer.
- mux_in  input  DATA_W  byte returned from the multiplexer.
- out_data  output  DATA_W  captured byte.
- out_ch  output  SEL_W  channel the byte came from.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse when the last enabled channel of a frame is accepted.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0 (mux_sel, out_data, out_ch, out_valid, busy, frame_done); internal mask, dwell, counter and stop_pending cleared. Reset mid-scan abandons the scan immediately; any pending out_valid is dropped.
- All state and outputs are registered; mux_sel is never combinational from inputs.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - On an edge with start=1 and ch_mask!=0: latch ch_mask, dwell and cont; set mux_sel to the lowest set mask bit; load cnt=dwell; enter SETTLE.
  - start with ch_mask==0 is ignored; the block stays in IDLE.
  - stop in IDLE is ignored.
  - mux_sel holds its last value.
- SETTLE:
  - On each edge with cnt!=0: decrement cnt.
  - On the edge with cnt==0: out_data<=mux_in, out_ch<=mux_sel, out_valid<=1; enter HOLD.
  - Latency: with start sampled at edge E0, out_valid rises after edge E0+dwell+1, so mux_sel is stable dwell+1 cycles before the sample. dwell=0 gives capture one edge after select.
- HOLD:
  - out_valid, out_data and out_ch stay stable until an edge with out_ready=1; mux_sel is unchanged.
  - On the accepting edge: out_valid<=0, then:
    - If a higher enabled channel exists: mux_sel<=next higher set bit, cnt<=dwell, enter SETTLE.
    - Otherwise the frame is complete: frame_done pulses high for exactly one cycle.
      - If cont=1 and stop_pending=0: mux_sel<=lowest set bit, cnt<=dwell, enter SETTLE (wrap-around).
      - Else: enter IDLE.
  - If stop_pending=1: enter IDLE after this acceptance regardless of the remaining channels. frame_done pulses only if the accepted channel was the last enabled one.
- stop while busy sets stop_pending; it is cleared on entry to IDLE. stop and start in the same cycle while in IDLE: start wins and stop is ignored.
- start while busy is ignored. ch_mask and dwell changes while busy have no effect until the next start.
- mux_sel values >= NUM_CH are never driven.
- The next mux_sel is chosen by priority search over the latched mask, from current+1 upward.
- Throughput: one word per dwell+2 cycles when out_ready is held high.

Test Plan:
- Reset mid-HOLD with out_valid=1 -> all outputs 0 in the same cycle; busy=0; a later start works normally.
- start, ch_mask=6'b111111, dwell=0, cont=0, out_ready=1, mux_in=8'h10+sel -> words (0,10),(1,11),...,(5,15), one every 2 cycles; frame_done pulses with the (5,15) acceptance; busy drops the next cycle.
- ch_mask=6'b100101, dwell=3 -> mux_sel visits only 0, 2, 5; each capture occurs 4 edges after the select change; out_ch matches 0, 2, 5.
- out_ready held low 10 cycles while in HOLD, mux_in changing -> out_data frozen at the captured value, mux_sel unchanged; release -> advance to the next channel.
- cont=1, ch_mask=6'b000011 -> sequence 0,1,0,1,... with frame_done after every channel-1 acceptance; stop asserted during channel 0 SETTLE -> channel 0 delivered, then IDLE with no frame_done.
- start with ch_mask=0 -> busy stays 0 and no out_valid; start pulsed while busy -> no restart, sequence unchanged.
